// File: rtl/rca_pkg.sv
// Shared types for the ripple-carry adder family (pipelined adder, its interface and testers).
package rca_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Operand B as seen by the adder: SUB adds the one's complement.
  function automatic logic [63:0] cond_b(input op_e op, input logic [63:0] b);
    return (op == OP_SUB) ? ~b : b;
  endfunction

  // Carry into the least-significant slice: SUB forces +1, ADD uses the caller's carry.
  function automatic logic cond_cin(input op_e op, input logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder; one instance per pipeline stage of rca_pipe.
module rca_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic c;
    // NOTE: every output gets a default before the loop so no path can leave it unassigned
    // (that would infer a latch); blocking '=' lets c ripple bit by bit within one evaluation.
    sum = '0;
    c   = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined N-bit ripple-carry adder/subtractor: one W-bit slice per stage, carry registered
// between stages, skewed operands and deskewed sums so all slices of an op leave together.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  op_e          in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int W = (STAGES > 0) ? N / STAGES : 1;

  if ((STAGES == 0) ? 1'b1 : (N % STAGES != 0)) begin : g_bad_cfg
    $fatal(1, "rca_pipe: N must be a multiple of STAGES and STAGES must be non-zero");
  end

  // acc_q[k] holds finished sum slices in its upper k*W bits and the not-yet-added slices of A
  // in its lower bits; each stage shifts right by W and drops its new sum slice in at the top.
  logic         valid_q    [STAGES];
  logic         carry_q    [STAGES];
  logic [N-1:0] acc_q      [STAGES];
  logic [N-1:0] opb_q      [STAGES];
  logic [W-1:0] slice_sum  [STAGES];
  logic         slice_cout [STAGES];
  logic         adv;
  logic [N-1:0] b_cond;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_cond   = N'(cond_b(in_op, 64'(in_b)));

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    rca_slice #(.W(W)) u_slice (
      .a   (acc_q[k][W-1:0]),
      .b   (opb_q[k][W-1:0]),
      .cin (carry_q[k]),
      .sum (slice_sum[k]),
      .cout(slice_cout[k])
    );
  end

  function automatic logic [N-1:0] shift_in(input logic [N-1:0] acc, input logic [W-1:0] s);
    return (acc >> W) | (N'(s) << (N - W));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared along with the valids so no stale operand or
      // result is ever visible after reset; '<=' throughout keeps every stage edge-aligned.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        acc_q[k]   <= '0;
        opb_q[k]   <= '0;
      end
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      valid_q[0] <= in_valid;
      carry_q[0] <= cond_cin(in_op, in_cin);
      acc_q[0]   <= in_a;
      opb_q[0]   <= b_cond;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        carry_q[k] <= slice_cout[k-1];
        acc_q[k]   <= shift_in(acc_q[k-1], slice_sum[k-1]);
        opb_q[k]   <= opb_q[k-1] >> W;
      end
      out_valid <= valid_q[STAGES-1];
      // Result registers only load on a real beat so they hold after the final pop.
      if (valid_q[STAGES-1]) begin
        out_sum  <= shift_in(acc_q[STAGES-1], slice_sum[STAGES-1]);
        out_cout <= slice_cout[STAGES-1];
        out_ovf  <= (acc_q[STAGES-1][W-1] == opb_q[STAGES-1][W-1]) &&
                    (slice_sum[STAGES-1][W-1] != acc_q[STAGES-1][W-1]);
      end
    end
  end

endmodule

// File: tb/tb_rca_pipe.sv
// Directed bench for rca_pipe: arithmetic corners, latency, stall/stream ordering, async reset,
// and depth-1 / depth-32 builds sharing the same stimulus.
module tb_rca_pipe;
  import rca_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_cin;
  op_e          in_op;
  logic [N-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [N-1:0] out_sum;

  logic         s1_ready, s1_valid, s1_cout, s1_ovf;
  logic [N-1:0] s1_sum;
  logic         s32_ready, s32_valid, s32_cout, s32_ovf;
  logic [N-1:0] s32_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rca_pipe #(.N(N), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  rca_pipe #(.N(N), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s1_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(s1_valid), .out_ready(1'b1),
    .out_sum(s1_sum), .out_cout(s1_cout), .out_ovf(s1_ovf)
  );

  rca_pipe #(.N(N), .STAGES(32)) u_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s32_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(s32_valid), .out_ready(1'b1),
    .out_sum(s32_sum), .out_cout(s32_cout), .out_ovf(s32_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One isolated op on the 4-stage DUT: latency, result, then the post-pop hold.
  task automatic do_op(input string tag, input op_e op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic cin, input logic [N-1:0] e_sum,
                       input logic e_cout, input logic e_ovf);
    int lat;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_res"}, 64'({out_sum, out_cout, out_ovf}), 64'({e_sum, e_cout, e_ovf}));
    @(negedge clk);
    check({tag, "_hold"}, 64'({out_valid, out_sum}), 64'({1'b0, e_sum}));
  endtask

  op_e          s_op  [8] = '{OP_ADD, OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD, OP_SUB, OP_ADD};
  logic [N-1:0] s_a   [8] = '{32'h00000001, 32'h000000FF, 32'h00000010, 32'h12345678,
                              32'h00000000, 32'h80000000, 32'h7FFFFFFF, 32'h00FF00FF};
  logic [N-1:0] s_b   [8] = '{32'h00000002, 32'h00000001, 32'h00000001, 32'h11111111,
                              32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h00FF00FF};
  logic [7:0]   s_cin     = 8'b1001_1000;
  logic [33:0]  s_exp [8] = '{{32'h00000003, 1'b0, 1'b0}, {32'h00000100, 1'b0, 1'b0},
                              {32'h0000000F, 1'b1, 1'b0}, {32'h2345678A, 1'b0, 1'b0},
                              {32'hFFFFFFFF, 1'b0, 1'b0}, {32'h00000000, 1'b1, 1'b1},
                              {32'h80000000, 1'b0, 1'b1}, {32'h01FE01FF, 1'b0, 1'b0}};

  initial begin
    int tx, rx, cyc, beats, lat4, lat1, lat32;
    logic stall;
    logic [N-1:0] sum4, sum1, sum32;

    rst_n = 1'b0; in_valid = 1'b0; in_op = OP_ADD; in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out", 64'({out_valid, out_cout, out_ovf, out_sum}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 64'(in_ready), 64'd1);

    // Carry rippling across slice boundaries at three depths.
    in_op = OP_ADD; in_a = 32'h0000FFFF; in_b = 32'h00000001; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat4 = -1; lat1 = -1; lat32 = -1;
    sum4 = '0; sum1 = '0; sum32 = '0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid && lat4 < 0) begin lat4 = k; sum4 = out_sum; end
      if (s1_valid && lat1 < 0) begin lat1 = k; sum1 = s1_sum; end
      if (s32_valid && lat32 < 0) begin lat32 = k; sum32 = s32_sum; end
      @(negedge clk);
    end
    check("d4_lat", 64'(lat4), 64'd4);
    check("d4_sum", 64'(sum4), 64'h00010000);
    check("d1_lat", 64'(lat1), 64'd1);
    check("d1_sum", 64'(sum1), 64'h00010000);
    check("d32_lat", 64'(lat32), 64'd32);
    check("d32_sum", 64'(sum32), 64'h00010000);

    do_op("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    do_op("add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    do_op("add_cin",  OP_ADD, 32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0);
    do_op("sub_neg",  OP_SUB, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",  OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Back-to-back stream with a three-cycle consumer stall once results are flowing.
    tx = 0; rx = 0; cyc = 0;
    while (rx < 8 && cyc < 60) begin
      @(negedge clk);
      stall     = (cyc >= 6 && cyc <= 8);
      out_ready = !stall;
      in_valid  = (tx < 8);
      if (tx < 8) begin
        in_op = s_op[tx]; in_a = s_a[tx]; in_b = s_b[tx]; in_cin = s_cin[tx];
      end
      #1;
      check($sformatf("s_rdy%0d", cyc), 64'(in_ready), 64'(!stall));
      if (out_valid) begin
        check($sformatf("s_res%0d", rx), 64'({out_sum, out_cout, out_ovf}), 64'(s_exp[rx]));
        if (out_ready) rx++;
      end
      if (in_valid && in_ready) tx++;
      cyc++;
    end
    check("s_count", 64'(rx), 64'd8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Async reset with one result presented and three ops still in the stages.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_op = OP_ADD; in_a = 32'h11111111; in_b = 32'(i); in_cin = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst", 64'({out_valid, out_sum}), 64'({1'b1, 32'h11111111}));
    rst_n = 1'b0;
    #1;
    check("rst_async", 64'({out_valid, out_cout, out_ovf, out_sum}), 64'd0);
    check("rst_async_rdy", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beats = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      beats += int'(out_valid) + int'(s1_valid) + int'(s32_valid);
    end
    check("rst_stale", 64'(beats), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
